// File: rtl/uart_rx_8n1_if.sv
// UART receive-side bundle: the asynchronous serial line into the receiver and
// the recovered byte strobe, byte value and framing-error pulse out of it.
// No flow control: the consumer must take data in the same cycle wr is high.
//
// Signals:
//   rx         serial line, idle high, asynchronous to the receiver clock
//   wr         one-cycle strobe, data holds a new good byte
//   data       last good byte received (LSB first on the wire)
//   frame_err  one-cycle pulse, stop bit sampled low
`timescale 1ns/1ps
interface uart_rx_8n1_if;
  logic       rx;
  logic       wr;
  logic [7:0] data;
  logic       frame_err;

  // master: the receiver (consumes the line, produces the byte stream)
  modport master (input rx, output wr, output data, output frame_err);
  // slave: line driver / byte consumer
  modport slave  (output rx, input wr, input data, input frame_err);
endinterface

// File: rtl/uart_rx_8n1.sv
// Purpose: 8N1 UART receiver; 2-flop line synchroniser, start-bit qualify, mid-bit sampling.
// Latency: line fall to START is 3 clocks; wr rises 1 clock after the stop-bit mid-sample.
// Backpressure: none; the consumer must take data on wr, data holds until the next wr.
//
// Ports:
//   clk  in   system clock, all logic on posedge
//   rst  in   asynchronous active-high reset
//   bus  master modport of uart_rx_8n1_if (rx in; wr, data, frame_err out)
`timescale 1ns/1ps
module uart_rx_8n1 #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_8n1_if.master bus
);

  // Half a baud from the detected start edge lands the first sample mid-start-bit.
  localparam logic [23:0] HALF_M1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] FULL_M1 = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [23:0] counter;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  wire sample = (counter == 24'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      state         <= S_IDLE;
      counter       <= 24'd0;
      bit_idx       <= 3'd0;
      shreg         <= 8'h00;
      bus.wr        <= 1'b0;
      bus.data      <= 8'h00;
      bus.frame_err <= 1'b0;
    end else begin
      rx_m          <= bus.rx;
      rx_s          <= rx_m;
      bus.wr        <= 1'b0;
      bus.frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            counter <= HALF_M1;
          end
        end

        S_START: begin
          if (sample) begin
            if (rx_s) begin
              // Line went back high before mid-start: treat as a glitch.
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
              counter <= FULL_M1;
            end
          end else begin
            counter <= counter - 24'd1;
          end
        end

        S_DATA: begin
          if (sample) begin
            // LSB arrives first, so shift right and insert at the MSB.
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            counter <= FULL_M1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            counter <= counter - 24'd1;
          end
        end

        S_STOP: begin
          if (sample) begin
            // Return to IDLE at mid-stop so a following start edge is never missed.
            if (rx_s) begin
              bus.wr   <= 1'b1;
              bus.data <= shreg;
              state    <= S_IDLE;
            end else begin
              bus.frame_err <= 1'b1;
              state         <= S_BREAK;
            end
          end else begin
            counter <= counter - 24'd1;
          end
        end

        S_BREAK: begin
          // A held-low line reports one framing error, then waits for idle.
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  a_excl:    assert property (@(posedge clk) disable iff (rst) !(bus.wr && bus.frame_err));
  a_counter: assert property (@(posedge clk) disable iff (rst) counter < CLOCKS_PER_BAUD);
  a_wr_src:  assert property (@(posedge clk) disable iff (rst) bus.wr |-> ($past(state) == S_STOP));

endmodule
